// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU data-bus to wait-stated SRAM controller; optional MEM_ALIGN_CHECK_EN misaligned-access trap
module data_mem_ctrl #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [31:0]   i_cpu_addr,
    input  logic [31:0]   i_cpu_wdata,
    input  logic          i_cpu_read,
    input  logic          i_cpu_wrt,
    output logic [31:0]   o_cpu_rdata,
    output logic          o_cpu_stall,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic          o_mem_ce,
    output logic          o_mem_we,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    // Counter preload so that WAIT lasts exactly WAIT_STATES cycles
    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic            r_op_wr;
    logic [31:0]     r_cpu_rdata;
    logic [AW-1:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic            w_req;
    logic            w_misalign;
    logic            w_last;
    logic            w_unused;

    assign w_req = i_cpu_read | i_cpu_wrt;

    // Byte-lane and high address bits are not decoded; words alias modulo 2^AW
    assign w_unused = &{1'b0, i_cpu_addr[31:AW+2], i_cpu_addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign;
    assign w_misalign = (i_cpu_addr[1:0] != 2'b00);
    assign o_err      = (r_state == S_RESP) && r_misalign;
`else
    assign w_misalign = 1'b0;
    assign o_err      = 1'b0;
`endif

    // Last cycle the SRAM is enabled: read data is sampled on the edge that ends it
    assign w_last = ((r_state == S_ACCESS) && (WAIT_STATES == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd0));

    // State register; reset aborts any access in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and SRAM/core handshake outputs
    always_comb begin
        w_next      = r_state;
        o_mem_ce    = 1'b0;
        o_mem_we    = 1'b0;
        o_cpu_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_cpu_stall = w_req & i_rst_n;
                if (w_req) begin
                    w_next = w_misalign ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                o_mem_ce    = 1'b1;
                o_mem_we    = r_op_wr;
                o_cpu_stall = 1'b1;
                w_next      = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                o_mem_ce    = 1'b1;
                o_mem_we    = r_op_wr;
                o_cpu_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, wait counter and load-data capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= 4'd0;
            r_op_wr     <= 1'b0;
            r_cpu_rdata <= 32'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_mem_addr  <= i_cpu_addr[AW+1:2];
                        r_mem_wdata <= i_cpu_wdata;
                        r_op_wr     <= i_cpu_wrt;
`ifdef MEM_ALIGN_CHECK_EN
                        r_misalign  <= w_misalign;
`endif
                        if (w_misalign) begin
                            r_cpu_rdata <= 32'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_cnt <= WS_LOAD;
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
            if (w_last && !r_op_wr) begin
                r_cpu_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_cpu_rdata = r_cpu_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
